// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage program-counter controller.
//
// Holds the fetch PC and picks the next PC from one of these sources, in
// priority order:
//   trap > stall hold / redirect capture > live redirect > pending redirect
//   > return-address-stack pop > sequential step.
// A redirect that arrives while fetch is stalled is kept in a pending
// register and applied on the first unstalled cycle. Loaded targets are
// forced to instruction alignment, and the forcing is reported on
// misalign_err.
//
// Optional build macro: PC_RAS_EN adds a RAS_DEPTH-entry circular
// return-address stack. Without it, ras_push/ras_pop are ignored and
// ras_valid is tied to 0. The port list is the same in both builds.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   StallF            fetch stall from the hazard unit (PC holds)
//   redirect_valid/_target   branch/jump redirect resolved in EX
//   trap_valid/trap_vector   exception/interrupt entry
//   ras_push/ras_push_addr   push a return address
//   ras_pop                  redirect to the top of the stack
//   pc_out, pc_plus_out      fetch address and fetch address + INSTR_BYTES
//   fetch_valid              pc_out is a fetch the pipeline must consume
//   redirect_pending         a captured redirect is waiting to be applied
//   misalign_err             last loaded target had nonzero low bits
//   ras_valid                return-address stack is non-empty
module pc_ctrl #(
  parameter int             N           = 32,
  parameter logic [N-1:0]   RESET_ADDR  = '0,
  parameter int             INSTR_BYTES = 4,
  parameter int             RAS_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         StallF,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_target,
  input  logic         trap_valid,
  input  logic [N-1:0] trap_vector,
  input  logic         ras_push,
  input  logic [N-1:0] ras_push_addr,
  input  logic         ras_pop,
  output logic [N-1:0] pc_out,
  output logic [N-1:0] pc_plus_out,
  output logic         fetch_valid,
  output logic         redirect_pending,
  output logic         misalign_err,
  output logic         ras_valid
);

  localparam logic [N-1:0] STEP     = N'(INSTR_BYTES);
  localparam logic [N-1:0] LOW_MASK = N'(INSTR_BYTES - 1);

  // S_BOOT holds the PC for the first cycle after reset so that RESET_ADDR
  // is presented once with fetch_valid=1 before sequential stepping starts.
  typedef enum logic {S_BOOT, S_RUN} state_t;

  state_t       state_reg, state_next;
  logic [N-1:0] pc_reg, pc_next;
  logic         fetch_valid_reg, fetch_valid_next;
  logic         pend_valid_reg, pend_valid_next;
  logic [N-1:0] pend_target_reg, pend_target_next;
  logic         misalign_reg, misalign_next;
  logic         load;
  logic [N-1:0] load_target;
  logic         ras_do_pop;
  logic [N-1:0] ras_top;
  logic         ras_nonempty;

  always_comb begin
    state_next       = S_RUN;
    pc_next          = pc_reg;
    fetch_valid_next = 1'b1;
    pend_valid_next  = pend_valid_reg;
    pend_target_next = pend_target_reg;
    misalign_next    = 1'b0;
    load             = 1'b0;
    load_target      = '0;
    ras_do_pop       = 1'b0;

    if (trap_valid) begin
      load            = 1'b1;
      load_target     = trap_vector;
      pend_valid_next = 1'b0;
    end else if (StallF) begin
      // PC holds; a redirect seen now is remembered (latest one wins).
      if (redirect_valid) begin
        pend_valid_next  = 1'b1;
        pend_target_next = redirect_target;
      end
    end else if (redirect_valid) begin
      load            = 1'b1;
      load_target     = redirect_target;
      pend_valid_next = 1'b0;
    end else if (pend_valid_reg) begin
      load            = 1'b1;
      load_target     = pend_target_reg;
      pend_valid_next = 1'b0;
    end else if (ras_pop && ras_nonempty) begin
      load        = 1'b1;
      load_target = ras_top;
      ras_do_pop  = 1'b1;
    end else if (state_reg == S_RUN) begin
      pc_next = pc_reg + STEP;
    end

    if (load) begin
      pc_next          = load_target & ~LOW_MASK;
      misalign_next    = |(load_target & LOW_MASK);
      fetch_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_BOOT;
      pc_reg          <= RESET_ADDR;
      fetch_valid_reg <= 1'b0;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= '0;
      misalign_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      fetch_valid_reg <= fetch_valid_next;
      pend_valid_reg  <= pend_valid_next;
      pend_target_reg <= pend_target_next;
      misalign_reg    <= misalign_next;
    end
  end

`ifdef PC_RAS_EN
  localparam int             PW   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int             CW   = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0]  LAST = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0]  FULL = CW'(RAS_DEPTH);

  logic [N-1:0]  ras_mem [RAS_DEPTH];
  logic [PW-1:0] top_reg, top_next, top_inc, top_dec, wr_idx;
  logic [CW-1:0] count_reg, count_next;

  // top_reg points at the newest entry; pushing past full wraps onto the
  // oldest slot, which is exactly the overwrite-oldest behaviour wanted.
  assign top_inc      = (top_reg == LAST) ? '0 : top_reg + PW'(1);
  assign top_dec      = (top_reg == '0) ? LAST : top_reg - PW'(1);
  assign ras_top      = ras_mem[top_reg];
  assign ras_nonempty = (count_reg != '0);

  always_comb begin
    top_next   = top_reg;
    count_next = count_reg;
    wr_idx     = top_inc;
    if (ras_push && ras_do_pop) begin
      // Pop consumes the old top this cycle; the push takes its slot.
      wr_idx = top_reg;
    end else if (ras_push) begin
      top_next = top_inc;
      if (count_reg != FULL) count_next = count_reg + CW'(1);
    end else if (ras_do_pop) begin
      top_next   = top_dec;
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_reg   <= '0;
      count_reg <= '0;
    end else begin
      top_reg   <= top_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push && !reset) ras_mem[wr_idx] <= ras_push_addr;
  end
`else
  assign ras_top      = '0;
  assign ras_nonempty = 1'b0;

  logic unused_ras;
  assign unused_ras = ^{ras_push, ras_push_addr, ras_do_pop};
`endif

  assign pc_out           = pc_reg;
  assign pc_plus_out      = pc_reg + STEP;
  assign fetch_valid      = fetch_valid_reg;
  assign redirect_pending = pend_valid_reg;
  assign misalign_err     = misalign_reg;
  assign ras_valid        = ras_nonempty;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: self-checking bench for pc_ctrl. Directed scenarios followed
// by a randomized phase; every cycle the DUT outputs are compared against a
// behavioural model (PC as plain arithmetic, return stack as a queue).
module tb_pc_ctrl;
  localparam int N = 32;
  localparam int DEPTH = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, StallF, redirect_valid, trap_valid, ras_push, ras_pop;
  logic [N-1:0] redirect_target, trap_vector, ras_push_addr;
  logic [N-1:0] pc_out, pc_plus_out;
  logic         fetch_valid, redirect_pending, misalign_err, ras_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_ctrl #(.N(N), .RESET_ADDR('0), .INSTR_BYTES(4), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .StallF(StallF),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .pc_out(pc_out), .pc_plus_out(pc_plus_out), .fetch_valid(fetch_valid),
    .redirect_pending(redirect_pending), .misalign_err(misalign_err),
    .ras_valid(ras_valid)
  );

  // Reference model state
  logic [N-1:0] m_pc, m_pend;
  bit           m_fv, m_pv, m_mis, m_boot;
  logic [N-1:0] m_stack[$];

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Advance the model across one rising edge using the inputs now driven.
  task automatic model_edge();
    bit           ld;
    logic [N-1:0] tgt, nxt;
    bit           popped;
    if (reset) begin
      m_pc = '0; m_fv = 0; m_pv = 0; m_mis = 0; m_boot = 1; m_pend = '0;
      m_stack.delete();
      return;
    end
    ld = 0; tgt = '0; popped = 0; nxt = m_pc;
    if (trap_valid) begin
      ld = 1; tgt = trap_vector; m_pv = 0;
    end else if (StallF) begin
      if (redirect_valid) begin m_pv = 1; m_pend = redirect_target; end
    end else if (redirect_valid) begin
      ld = 1; tgt = redirect_target; m_pv = 0;
    end else if (m_pv) begin
      ld = 1; tgt = m_pend; m_pv = 0;
    end else if (RAS_ON && ras_pop && m_stack.size() > 0) begin
      ld = 1; tgt = m_stack[$]; popped = 1;
    end else if (!m_boot) begin
      nxt = m_pc + 32'd4;
    end
    if (popped) void'(m_stack.pop_back());
    if (RAS_ON && ras_push) begin
      m_stack.push_back(ras_push_addr);
      if (m_stack.size() > DEPTH) m_stack.delete(0);
    end
    m_pc   = ld ? (tgt & ~32'd3) : nxt;
    m_mis  = ld && (tgt[1:0] != 2'b00);
    m_fv   = !ld;
    m_boot = 0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, " pc_out"}, pc_out, m_pc);
    chk({tag, " pc_plus_out"}, pc_plus_out, m_pc + 32'd4);
    chk({tag, " fetch_valid"}, {31'd0, fetch_valid}, {31'd0, m_fv});
    chk({tag, " redirect_pending"}, {31'd0, redirect_pending}, {31'd0, m_pv});
    chk({tag, " misalign_err"}, {31'd0, misalign_err}, {31'd0, m_mis});
    chk({tag, " ras_valid"}, {31'd0, ras_valid}, {31'd0, (m_stack.size() > 0)});
    $display("cyc %s: pc=%h fv=%0b pend=%0b mis=%0b rasv=%0b", tag, pc_out,
             fetch_valid, redirect_pending, misalign_err, ras_valid);
  endtask

  task automatic idle();
    reset = 0; StallF = 0; redirect_valid = 0; trap_valid = 0;
    ras_push = 0; ras_pop = 0;
    redirect_target = '0; trap_vector = '0; ras_push_addr = '0;
  endtask

  initial begin
    logic [N-1:0] r;
    idle();
    m_pc = '0; m_pend = '0; m_fv = 0; m_pv = 0; m_mis = 0; m_boot = 1;

    // 1: reset then free-running sequence 0,0,4,8,12
    reset = 1;
    for (int i = 0; i < 3; i++) step("reset");
    chk("t1 reset pc", pc_out, 32'h0);
    chk("t1 reset fv", {31'd0, fetch_valid}, 32'd0);
    reset = 0;
    step("t1"); chk("t1 first pc", pc_out, 32'h0); chk("t1 first fv", {31'd0, fetch_valid}, 32'd1);
    step("t1"); chk("t1 pc4", pc_out, 32'h4);
    step("t1"); step("t1"); step("t1"); chk("t1 pc10", pc_out, 32'h10);

    // 2: stall with redirect captured, applied after release
    StallF = 1; redirect_valid = 1; redirect_target = 32'h200;
    step("t2"); chk("t2 hold", pc_out, 32'h10); chk("t2 pend", {31'd0, redirect_pending}, 32'd1);
    redirect_valid = 0;
    step("t2");
    StallF = 0;
    step("t2"); chk("t2 load", pc_out, 32'h200); chk("t2 bubble", {31'd0, fetch_valid}, 32'd0);
    step("t2"); chk("t2 seq", pc_out, 32'h204);

    // 3: trap during stall beats stall and clears pending
    StallF = 1; redirect_valid = 1; redirect_target = 32'h300;
    step("t3");
    redirect_valid = 0; trap_valid = 1; trap_vector = 32'h80;
    step("t3"); chk("t3 trap", pc_out, 32'h80); chk("t3 pend clr", {31'd0, redirect_pending}, 32'd0);
    idle();
    step("t3");

    // 4: misaligned target, then wrap at top of address space
    redirect_valid = 1; redirect_target = 32'h103;
    step("t4"); chk("t4 aligned", pc_out, 32'h100); chk("t4 mis", {31'd0, misalign_err}, 32'd1);
    redirect_target = 32'hFFFF_FFFC;
    step("t4"); chk("t4 mis off", {31'd0, misalign_err}, 32'd0);
    redirect_valid = 0;
    step("t4"); chk("t4 wrap", pc_out, 32'h0);

    // 5: return-address stack overflow and drain
    for (int i = 1; i <= 5; i++) begin
      ras_push = 1; ras_push_addr = N'(i * 16);
      step("t5 push");
    end
    ras_push = 0; ras_pop = 1;
    for (int i = 5; i >= 2; i--) begin
      step("t5 pop");
      if (RAS_ON) chk("t5 pop pc", pc_out, N'(i * 16));
    end
    step("t5 pop empty");
    idle();

    // 6: trap + redirect + pop together: trap wins, stack untouched
    ras_push = 1; ras_push_addr = 32'h60;
    step("t6");
    ras_push = 0; trap_valid = 1; trap_vector = 32'h400;
    redirect_valid = 1; redirect_target = 32'h500; ras_pop = 1;
    step("t6"); chk("t6 trap", pc_out, 32'h400);
    trap_valid = 0; redirect_valid = 0;
    step("t6");
    if (RAS_ON) chk("t6 stack kept", pc_out, 32'h60);
    idle();

    // Reset mid-stall discards the pending redirect
    StallF = 1; redirect_valid = 1; redirect_target = 32'h700;
    step("t7");
    reset = 1;
    step("t7"); chk("t7 pend gone", {31'd0, redirect_pending}, 32'd0);
    idle();
    step("t7"); chk("t7 pc", pc_out, 32'h0);

    // Randomized phase
    for (int i = 0; i < 500; i++) begin
      reset          = ($urandom_range(0, 99) < 2);
      StallF         = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      r = $urandom;
      redirect_target = ($urandom_range(0, 3) == 0) ? r : (r & ~32'd3);
      trap_valid     = ($urandom_range(0, 19) == 0);
      trap_vector    = $urandom;
      ras_push       = ($urandom_range(0, 4) == 0);
      ras_push_addr  = $urandom;
      ras_pop        = ($urandom_range(0, 3) == 0);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
